// File: rtl/argmax_scan_if.sv
// Handshake and data bundle for the argmax scanner.
// The requester drives START/SCORES; the scanner returns status and result.
interface argmax_scan_if #(
  parameter int N_CLASS = 46,
  parameter int DW      = 32
);
  logic                  START;
  logic [N_CLASS*DW-1:0] SCORES;
  logic                  BUSY;
  logic                  DONE;
  logic [5:0]            CLASS;
  logic [DW-1:0]         MAX_VAL;
  logic                  VALID;

  modport master (
    output START, SCORES,
    input  BUSY, DONE, CLASS, MAX_VAL, VALID
  );

  modport slave (
    input  START, SCORES,
    output BUSY, DONE, CLASS, MAX_VAL, VALID
  );
endinterface

// File: rtl/argmax_scan.sv
// Sequential argmax over N_CLASS signed scores, one comparison per clock.
// Scores are snapshotted when a scan starts, so the bus may change freely
// during the scan. Ties keep the lowest class index.
module argmax_scan #(
  parameter int N_CLASS = 46,
  parameter int DW      = 32
) (
  input logic          CLK,
  input logic          RESET,
  argmax_scan_if.slave bus
);
  localparam int IW = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

  state_t                state_reg;
  logic [IW-1:0]         cnt_reg;
  logic [IW-1:0]         idx_reg;
  logic signed [DW-1:0]  max_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  valid_reg;
  logic [5:0]            class_reg;
  logic [DW-1:0]         max_val_reg;

  logic signed [DW-1:0]  score_in [N_CLASS];
  logic signed [DW-1:0]  snap_reg [N_CLASS];

  logic                  load;
  logic signed [DW-1:0]  cand;
  logic                  better;
  logic signed [DW-1:0]  max_next;
  logic [IW-1:0]         idx_next;

  // Unflatten the score bus, class 0 at the LSBs.
  for (genvar gi = 0; gi < N_CLASS; gi++) begin : g_unpack
    assign score_in[gi] = bus.SCORES[gi*DW +: DW];
  end

  assign load = (state_reg == IDLE) && bus.START && !RESET;

  // Snapshot of the scores, captured only when a scan is accepted.
  always_ff @(posedge CLK) begin
    if (load) begin
      snap_reg <= score_in;
    end
  end

  // Running comparison: strictly greater replaces, so ties keep the earlier index.
  always_comb begin
    cand     = snap_reg[cnt_reg];
    better   = (cand > max_reg);
    max_next = better ? cand : max_reg;
    idx_next = better ? cnt_reg : idx_reg;
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      max_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      class_reg   <= '0;
      max_val_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.START) begin
            busy_reg <= 1'b1;
            max_reg  <= score_in[0];
            idx_reg  <= '0;
            if (N_CLASS == 1) begin
              // Single class: nothing to compare, publish class 0 directly.
              state_reg   <= FIN;
              done_reg    <= 1'b1;
              valid_reg   <= 1'b1;
              class_reg   <= '0;
              max_val_reg <= score_in[0];
              cnt_reg     <= '0;
            end else begin
              state_reg <= SCAN;
              valid_reg <= 1'b0;
              cnt_reg   <= IW'(1);
            end
          end
        end
        SCAN: begin
          max_reg <= max_next;
          idx_reg <= idx_next;
          if (cnt_reg == IW'(N_CLASS - 1)) begin
            // Last comparison: publish the result in the same edge.
            state_reg   <= FIN;
            cnt_reg     <= '0;
            done_reg    <= 1'b1;
            valid_reg   <= 1'b1;
            class_reg   <= 6'(idx_next);
            max_val_reg <= max_next;
          end else begin
            cnt_reg <= cnt_reg + IW'(1);
          end
        end
        FIN: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.BUSY    = busy_reg;
  assign bus.DONE    = done_reg;
  assign bus.VALID   = valid_reg;
  assign bus.CLASS   = class_reg;
  assign bus.MAX_VAL = max_val_reg;
endmodule

// File: tb/tb_argmax_scan.sv
// Self-checking bench for argmax_scan: directed scenarios plus random scans
// compared against a plain loop-based argmax model.
module tb_argmax_scan;
  localparam int N  = 46;
  localparam int DW = 32;
  localparam int SW = N * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  argmax_scan_if #(.N_CLASS(N), .DW(DW)) bus ();

  argmax_scan #(.N_CLASS(N), .DW(DW)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: first index holding the largest signed value.
  function automatic void model(input int sc[N], output int idx, output logic [DW-1:0] mx);
    int best;
    best = sc[0];
    idx  = 0;
    foreach (sc[i]) if (sc[i] > best) begin best = sc[i]; idx = i; end
    mx = best;
  endfunction

  function automatic logic [SW-1:0] pack(input int sc[N]);
    logic [SW-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p[i*DW +: DW] = sc[i];
    return p;
  endfunction

  // One full scan: scores sc on the START edge, sc_after from the next cycle on.
  task automatic scan_and_check(input string tag, input int sc[N], input int sc_after[N]);
    int eidx, lat, bcnt;
    logic [DW-1:0] emx;
    bit got;
    model(sc, eidx, emx);
    @(negedge clk);
    bus.SCORES = pack(sc);
    bus.START  = 1'b1;
    @(negedge clk);
    bus.START  = 1'b0;
    bus.SCORES = pack(sc_after);
    check({tag, "_valid_clear"}, 64'(bus.VALID), 64'd0);
    got = 0; lat = 0; bcnt = 0;
    for (int j = 0; j < 200; j++) begin
      if (bus.BUSY) bcnt++;
      if (bus.DONE) begin got = 1; lat = j; break; end
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(N - 1));
    check({tag, "_class"}, 64'(bus.CLASS), 64'(eidx));
    check({tag, "_max"}, 64'(bus.MAX_VAL), 64'(emx));
    check({tag, "_valid"}, 64'(bus.VALID), 64'd1);
    check({tag, "_busy_cycles"}, 64'(bcnt), 64'(N));
    @(negedge clk);
    check({tag, "_idle_busy"}, 64'(bus.BUSY), 64'd0);
    check({tag, "_single_done"}, 64'(bus.DONE), 64'd0);
    check({tag, "_class_hold"}, 64'(bus.CLASS), 64'(eidx));
    $display("scan %s: class=%0d max=%0h latency=%0d busy=%0d", tag, bus.CLASS, bus.MAX_VAL, lat, bcnt);
  endtask

  initial begin
    int a[N];
    int b[N];
    int eidx;
    logic [DW-1:0] emx;
    int done_t[$];
    int low_run, max_low;
    bit seen;

    bus.START  = 1'b0;
    bus.SCORES = '0;

    // Reset, with START asserted to show reset wins.
    bus.START = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.BUSY), 64'd0);
    check("rst_done", 64'(bus.DONE), 64'd0);
    check("rst_valid", 64'(bus.VALID), 64'd0);
    check("rst_class", 64'(bus.CLASS), 64'd0);
    check("rst_max", 64'(bus.MAX_VAL), 64'd0);
    bus.START = 1'b0;
    rst = 1'b0;
    $display("reset: outputs checked");

    // Ascending scores.
    for (int i = 0; i < N; i++) a[i] = i * 3;
    scan_and_check("ascending", a, a);

    // Tie between 17 and 30 resolves to 17.
    for (int i = 0; i < N; i++) a[i] = -5;
    a[17] = -1; a[30] = -1;
    scan_and_check("tie", a, a);

    // Signed extremes.
    for (int i = 0; i < N; i++) a[i] = 0;
    a[0] = 32'h7FFFFFFF; a[1] = 32'h80000000;
    scan_and_check("extreme_a", a, a);
    a[0] = 32'h80000000;
    scan_and_check("extreme_b", a, a);

    // Scores change right after START; snapshot must be used.
    for (int i = 0; i < N; i++) begin a[i] = 0; b[i] = 0; end
    a[9] = 100;
    scan_and_check("snapshot", a, b);

    // Winner in the last slot, all negative.
    for (int i = 0; i < N; i++) a[i] = -100 - i;
    a[N-1] = -2;
    scan_and_check("last_slot", a, a);

    // Reset mid-scan aborts without a DONE pulse.
    for (int i = 0; i < N; i++) a[i] = i;
    @(negedge clk);
    bus.SCORES = pack(a);
    bus.START  = 1'b1;
    @(negedge clk);
    bus.START  = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(bus.BUSY), 64'd0);
    check("abort_valid", 64'(bus.VALID), 64'd0);
    check("abort_class", 64'(bus.CLASS), 64'd0);
    check("abort_max", 64'(bus.MAX_VAL), 64'd0);
    seen = 0;
    for (int j = 0; j < 60; j++) begin
      if (bus.DONE) seen = 1;
      @(negedge clk);
    end
    check("abort_no_done", 64'(seen), 64'd0);
    $display("abort: done_seen=%0d", seen);
    a[5] = 1000;
    scan_and_check("after_abort", a, a);

    // Random scans; odd rounds use a narrow range to provoke ties.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        if (r % 2 == 1) a[i] = int'($urandom_range(0, 6)) - 3;
        else            a[i] = int'($urandom);
      end
      if (r == 4) a[$urandom_range(0, N-1)] = 32'h7FFFFFFF;
      scan_and_check($sformatf("random%0d", r), a, a);
    end

    // START held for 200 cycles: back-to-back scans every N+1 cycles.
    for (int i = 0; i < N; i++) a[i] = int'($urandom);
    model(a, eidx, emx);
    @(negedge clk);
    bus.SCORES = pack(a);
    bus.START  = 1'b1;
    low_run = 0; max_low = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.DONE) done_t.push_back(t);
      if (!bus.BUSY) begin
        low_run++;
        if (low_run > max_low) max_low = low_run;
      end else begin
        low_run = 0;
      end
    end
    bus.START = 1'b0;
    check("held_done_count", 64'(done_t.size()), 64'd4);
    if (done_t.size() > 0) check("held_first_done", 64'(done_t[0]), 64'(N - 1));
    for (int k = 1; k < done_t.size(); k++)
      check($sformatf("held_spacing%0d", k), 64'(done_t[k] - done_t[k-1]), 64'(N + 1));
    check("held_max_low_run", 64'(max_low), 64'd1);
    seen = 0;
    for (int j = 0; j < 100; j++) begin
      if (!bus.BUSY) begin seen = 1; break; end
      @(negedge clk);
    end
    check("held_drain", 64'(seen), 64'd1);
    check("held_class", 64'(bus.CLASS), 64'(eidx));
    check("held_max", 64'(bus.MAX_VAL), 64'(emx));
    $display("held start: dones=%0d max_low_run=%0d", done_t.size(), max_low);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
